// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Function : ALU funct codes, mul/div sequencer state type and decode helpers.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [5:0] FUNCT_SRL   = 6'd2;
  localparam logic [5:0] FUNCT_MFHI  = 6'd16;
  localparam logic [5:0] FUNCT_MFLO  = 6'd18;
  localparam logic [5:0] FUNCT_MULTU = 6'd25;
  localparam logic [5:0] FUNCT_DIVU  = 6'd27;
  localparam logic [5:0] FUNCT_ADD   = 6'd32;
  localparam logic [5:0] FUNCT_SUB   = 6'd34;
  localparam logic [5:0] FUNCT_AND   = 6'd36;
  localparam logic [5:0] FUNCT_OR    = 6'd37;
  localparam logic [5:0] FUNCT_SLT   = 6'd42;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  function automatic logic is_muldiv(input logic [5:0] funct);
    return (funct == FUNCT_MULTU) || (funct == FUNCT_DIVU);
  endfunction

  function automatic logic is_hilo_read(input logic [5:0] funct);
    return (funct == FUNCT_MFHI) || (funct == FUNCT_MFLO);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_sequencer_if.sv
// ============================================================================
// Module   : muldiv_sequencer_if
// Function : Issue-stage <-> mul/div sequencer request/interlock bundle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic [5:0]       Signal;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             req_ready;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Output;

  modport master (
    output req_valid, Signal, dataA, dataB,
    input  req_ready, stall, busy, done, Output
  );

  modport slave (
    input  req_valid, Signal, dataA, dataB,
    output req_ready, stall, busy, done, Output
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_iter_core.sv
// ============================================================================
// Module   : muldiv_iter_core
// Function : One shift-add multiply or restoring-divide step per enable.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_nxt_o,
  output logic [WIDTH-1:0] lo_nxt_o
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] shr_q, shr_d;
  logic [WIDTH-1:0] opnd_q;
  logic             div_q;
  logic [WIDTH:0]   w_sum, w_shift, w_diff;

  // Multiply: acc:shr holds the running product, shr starts as the multiplier.
  // Divide:   acc is the partial remainder, shr shifts dividend out / quotient in.
  always_comb begin
    w_sum   = {1'b0, acc_q} + {1'b0, opnd_q};
    w_shift = {acc_q, shr_q[WIDTH-1]};
    w_diff  = w_shift - {1'b0, opnd_q};
    acc_d   = acc_q;
    shr_d   = shr_q;
    if (div_q) begin
      if (w_shift >= {1'b0, opnd_q}) begin
        acc_d = w_diff[WIDTH-1:0];
        shr_d = {shr_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = w_shift[WIDTH-1:0];
        shr_d = {shr_q[WIDTH-2:0], 1'b0};
      end
    end else if (shr_q[0]) begin
      {acc_d, shr_d} = {w_sum, shr_q[WIDTH-1:1]};
    end else begin
      {acc_d, shr_d} = {1'b0, acc_q, shr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      shr_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else if (load_i) begin
      acc_q  <= '0;
      shr_q  <= is_div_i ? a_i : b_i;
      opnd_q <= is_div_i ? b_i : a_i;
      div_q  <= is_div_i;
    end else if (step_i) begin
      acc_q  <= acc_d;
      shr_q  <= shr_d;
    end
  end

  assign hi_nxt_o = acc_d;
  assign lo_nxt_o = shr_d;

endmodule

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module   : muldiv_sequencer
// Function : MULTU/DIVU sequencer with HI/LO, MFHI/MFLO reads and interlock.
//            Optional MULDIV_EARLY_OUT_EN: trivial operands finish in 1 edge.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  muldiv_sequencer_if.slave bus
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] w_core_hi, w_core_lo;
  logic [WIDTH-1:0] w_early_hi;
  logic             w_busy, w_accept, w_last, w_is_div, w_early;

  assign w_busy   = (state_q == ST_RUN);
  assign w_accept = bus.req_valid && !w_busy && is_muldiv(bus.Signal);
  assign w_last   = w_busy && (cnt_q == CNT_W'(WIDTH - 1));
  assign w_is_div = (bus.Signal == FUNCT_DIVU);

`ifdef MULDIV_EARLY_OUT_EN
  always_comb begin
    w_early    = 1'b0;
    w_early_hi = '0;
    if (w_is_div) begin
      w_early    = (bus.dataB != '0) && (bus.dataA < bus.dataB);
      w_early_hi = bus.dataA;
    end else begin
      w_early    = (bus.dataA == '0) || (bus.dataB == '0);
    end
  end
`else
  assign w_early    = 1'b0;
  assign w_early_hi = '0;
`endif

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load_i   (w_accept && !w_early),
    .step_i   (w_busy),
    .is_div_i (w_is_div),
    .a_i      (bus.dataA),
    .b_i      (bus.dataB),
    .hi_nxt_o (w_core_hi),
    .lo_nxt_o (w_core_lo)
  );

  // HI/LO take the core's post-step value on the final iteration edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (w_last) begin
          state_d = ST_DONE;
          hi_d    = w_core_hi;
          lo_d    = w_core_lo;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (w_accept) begin
          cnt_d = '0;
          if (w_early) begin
            state_d = ST_DONE;
            hi_d    = w_early_hi;
            lo_d    = '0;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy      = w_busy;
  assign bus.req_ready = !w_busy;
  assign bus.done      = (state_q == ST_DONE);
  assign bus.stall     = bus.req_valid && w_busy &&
                         (is_muldiv(bus.Signal) || is_hilo_read(bus.Signal));

  always_comb begin
    bus.Output = '0;
    if (bus.req_valid && !w_busy) begin
      if (bus.Signal == FUNCT_MFHI)      bus.Output = hi_q;
      else if (bus.Signal == FUNCT_MFLO) bus.Output = lo_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// Module   : tb_muldiv_sequencer
// Function : Directed self-checking bench for muldiv_sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;
  import alu_pkg::*;

  localparam int WIDTH = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int EO_LAT  = 1;
  localparam int EO_BUSY = 0;
`else
  localparam int EO_LAT  = 33;
  localparam int EO_BUSY = 32;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();

  muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for done, then read HI/LO back in the DONE cycle.
  task automatic run_op(input string tag, input logic [5:0] funct,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo,
                        input int exp_lat, input int exp_busy);
    int cyc;
    int bcnt;
    bus.req_valid = 1'b1;
    bus.Signal    = funct;
    bus.dataA     = a;
    bus.dataB     = b;
    #1;
    check({tag, ".ready"}, WIDTH'(bus.req_ready), 1);
    tick();
    bus.req_valid = 1'b0;
    bus.dataA     = ~a;
    bus.dataB     = ~b;
    cyc  = 1;
    bcnt = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.busy === 1'b1) bcnt++;
      tick();
      cyc++;
    end
    check({tag, ".latency"}, WIDTH'(cyc), WIDTH'(exp_lat));
    check({tag, ".busy_cycles"}, WIDTH'(bcnt), WIDTH'(exp_busy));
    bus.req_valid = 1'b1;
    bus.Signal    = FUNCT_MFHI;
    #1;
    check({tag, ".hi"}, bus.Output, exp_hi);
    bus.Signal = FUNCT_MFLO;
    #1;
    check({tag, ".lo"}, bus.Output, exp_lo);
    bus.req_valid = 1'b0;
    tick();
  endtask

  initial begin
    int cyc;
    int seen;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.Signal    = '0;
    bus.dataA     = '0;
    bus.dataB     = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst.busy", WIDTH'(bus.busy), 0);
    check("rst.done", WIDTH'(bus.done), 0);
    check("rst.ready", WIDTH'(bus.req_ready), 1);
    check("rst.stall", WIDTH'(bus.stall), 0);
    bus.req_valid = 1'b1;
    bus.Signal    = FUNCT_MFHI;
    #1;
    check("rst.mfhi", bus.Output, 0);
    bus.Signal = FUNCT_ADD;
    #1;
    check("rst.other_funct_stall", WIDTH'(bus.stall), 0);
    bus.req_valid = 1'b0;
    tick();

    run_op("mul7x6", FUNCT_MULTU, 32'd7, 32'd6, 32'd0, 32'd42, 33, 32);
    run_op("mulmax", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, 33, 32);
    run_op("div100_7", FUNCT_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, 32);
    run_op("div5_0", FUNCT_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 33, 32);

    // Interlock: MFHI and a second MULTU arrive mid-operation.
    bus.req_valid = 1'b1;
    bus.Signal    = FUNCT_MULTU;
    bus.dataA     = 32'h8000_0000;
    bus.dataB     = 32'd4;
    tick();
    bus.req_valid = 1'b0;
    cyc = 1;
    repeat (9) begin
      tick();
      cyc++;
    end
    bus.req_valid = 1'b1;
    bus.Signal    = FUNCT_MFHI;
    #1;
    check("intlk.mfhi_stall", WIDTH'(bus.stall), 1);
    check("intlk.mfhi_output", bus.Output, 0);
    bus.Signal = FUNCT_MULTU;
    bus.dataA  = 32'd3;
    bus.dataB  = 32'd5;
    #1;
    check("intlk.mul_stall", WIDTH'(bus.stall), 1);
    check("intlk.mul_ready", WIDTH'(bus.req_ready), 0);
    while (bus.done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("intlk.latency", WIDTH'(cyc), 33);
    check("intlk.done_stall", WIDTH'(bus.stall), 0);
    bus.Signal = FUNCT_MFHI;
    #1;
    check("intlk.done_mfhi", bus.Output, 32'd2);
    bus.Signal = FUNCT_MULTU;
    #1;
    check("intlk.done_ready", WIDTH'(bus.req_ready), 1);
    tick();
    check("intlk.b2b_busy", WIDTH'(bus.busy), 1);
    bus.req_valid = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("b2b.latency", WIDTH'(cyc), 33);
    bus.req_valid = 1'b1;
    bus.Signal    = FUNCT_MFHI;
    #1;
    check("b2b.hi", bus.Output, 32'd0);
    bus.Signal = FUNCT_MFLO;
    #1;
    check("b2b.lo", bus.Output, 32'd15);
    bus.req_valid = 1'b0;
    tick();

    // Reset in the middle of a divide discards it and clears HI/LO.
    run_op("mul3x4", FUNCT_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 33, 32);
    bus.req_valid = 1'b1;
    bus.Signal    = FUNCT_DIVU;
    bus.dataA     = 32'd9;
    bus.dataB     = 32'd2;
    tick();
    bus.req_valid = 1'b0;
    repeat (14) tick();
    check("mid.busy_before", WIDTH'(bus.busy), 1);
    #1;
    reset = 1'b1;
    #1;
    bus.req_valid = 1'b1;
    #1;
    check("arst.busy", WIDTH'(bus.busy), 0);
    check("arst.done", WIDTH'(bus.done), 0);
    check("arst.ready", WIDTH'(bus.req_ready), 1);
    check("arst.stall", WIDTH'(bus.stall), 0);
    bus.Signal = FUNCT_MFLO;
    #1;
    check("arst.lo", bus.Output, 0);
    bus.Signal = FUNCT_MFHI;
    #1;
    check("arst.hi", bus.Output, 0);
    bus.req_valid = 1'b0;
    tick();
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    check("arst.stays_idle", WIDTH'(seen), 0);

    run_op("eo_mul0", FUNCT_MULTU, 32'd0, 32'd123, 32'd0, 32'd0, EO_LAT, EO_BUSY);
    run_op("eo_div3_9", FUNCT_DIVU, 32'd3, 32'd9, 32'd3, 32'd0, EO_LAT, EO_BUSY);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
